// File: rtl/sad_pkg.sv
// Shared constants and FSM encoding for the windowed sum-of-absolute-differences block.
package sad_pkg;
    localparam int DIFF_W      = 13;
    localparam int WIN_LEN_DEF = 16;
    localparam int ACC_W_DEF   = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sad_state_t;
endpackage

// File: rtl/abs13_stage.sv
// Stage 1: magnitude of a signed difference, registered together with its valid bit.
module abs13_stage
    import sad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DIFF_W-1:0] i_diff,
    output logic [DIFF_W-1:0] o_mag,
    output logic              o_valid
);
    logic [DIFF_W-1:0] w_mag;

    // -4096 negates to bit pattern 1000..0, which read unsigned is exactly 4096.
    assign w_mag = i_diff[DIFF_W-1] ? (~i_diff + DIFF_W'(1)) : i_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mag   <= '0;
            o_valid <= 1'b0;
        end else if (i_clr) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_en;
            if (i_en) o_mag <= w_mag;
        end
    end
endmodule

// File: rtl/diff_sad_accum.sv
// Accumulates |in_diff| over WIN_LEN accepted samples and holds the sum until taken.
//  state    | meaning
//  ST_IDLE  | empty window, count=0, acc=0, ready for first sample
//  ST_ACCUM | window in progress, accepting samples
//  ST_DRAIN | last sample accepted, waiting for its magnitude to be added
//  ST_HOLD  | result valid on out_sad until handshake
module diff_sad_accum
    import sad_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DIFF_W-1:0] in_diff,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sad
);
    localparam int CNT_W = $clog2(WIN_LEN + 1);

    sad_state_t        r_state;
    sad_state_t        w_next;
    logic [CNT_W-1:0]  r_count;
    logic [ACC_W-1:0]  r_acc;
    logic              r_live;
    logic [DIFF_W-1:0] w_s1_mag;
    logic              w_s1_valid;
    logic              w_accept;
    logic              w_handshake;
    logic              w_last;

    assign w_accept    = in_valid && in_ready && !flush;
    assign w_handshake = (r_state == ST_HOLD) && out_ready;
    assign w_last      = (r_count == CNT_W'(WIN_LEN - 1));

    abs13_stage u_abs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept),
        .i_clr   (flush),
        .i_diff  (in_diff),
        .o_mag   (w_s1_mag),
        .o_valid (w_s1_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept) w_next = ST_ACCUM;
                ST_ACCUM: if (w_accept && w_last) w_next = ST_DRAIN;
                ST_DRAIN: if (!w_s1_valid) w_next = ST_HOLD;
                ST_HOLD:  if (out_ready) w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = r_live && ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
        out_valid = (r_state == ST_HOLD);
    end

    // Holds in_ready low during reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (flush || w_handshake) begin
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            if (w_accept)   r_count <= r_count + CNT_W'(1);
            if (w_s1_valid) r_acc   <= r_acc + ACC_W'(w_s1_mag);
        end
    end

    assign out_sad = r_acc;
endmodule

// File: tb/tb_diff_sad_accum.sv
// Directed bench for diff_sad_accum with WIN_LEN=4, ACC_W=15.
module tb_diff_sad_accum;
    localparam int WL = 4;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [12:0]   in_diff;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sad;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0][12:0] d;
        int               gap;
        int               exp;
    } vec_t;

    diff_sad_accum #(.WIN_LEN(WL), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_diff   (in_diff),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][12:0] mk(input int a, input int b, input int c, input int e);
        logic [3:0][12:0] v;
        v[0] = 13'(a);
        v[1] = 13'(b);
        v[2] = 13'(c);
        v[3] = 13'(e);
        return v;
    endfunction

    task automatic feed(input logic [3:0][12:0] d, input int gap, input string tag);
        for (int i = 0; i < WL; i++) begin
            chk({tag, "_in_ready"}, int'(in_ready), 1);
            in_valid = 1'b1;
            in_diff  = d[i];
            step();
            in_valid = 1'b0;
            if (i < WL - 1) repeat (gap) step();
        end
        chk({tag, "_drain_ready"}, int'(in_ready), 0);
    endtask

    task automatic expect_result(input int exp, input string tag);
        chk({tag, "_ov_e0"}, int'(out_valid), 0);
        step();
        chk({tag, "_ov_e1"}, int'(out_valid), 0);
        step();
        chk({tag, "_ov_e2"}, int'(out_valid), 1);
        chk({tag, "_sad"}, int'(out_sad), exp);
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ov_taken"}, int'(out_valid), 0);
        chk({tag, "_ready_after"}, int'(in_ready), 1);
    endtask

    task automatic run_window(input logic [3:0][12:0] d, input int gap, input int exp, input string tag);
        feed(d, gap, tag);
        expect_result(exp, tag);
        take(tag);
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{mk(5, -3, -4096, 4095), 0, 8199};
        tbl[1] = '{mk(1, 1, 1, 1), 2, 4};
        tbl[2] = '{mk(0, 0, 0, 0), 0, 0};
        tbl[3] = '{mk(-4096, -4096, -4096, -4096), 1, 16384};
        tbl[4] = '{mk(4095, -1, 2, -2), 3, 4100};

        rst_n = 1'b0; in_valid = 1'b0; in_diff = '0; flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sad", int'(out_sad), 0);
        #10 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 5; v++)
            run_window(tbl[v].d, tbl[v].gap, tbl[v].exp, $sformatf("vec%0d", v));

        // Result held with out_ready low while upstream keeps offering samples.
        feed(mk(5, -3, -4096, 4095), 0, "hold");
        expect_result(8199, "hold");
        in_valid = 1'b1;
        in_diff  = 13'd7;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("hold_sad_%0d", k), int'(out_sad), 8199);
            chk($sformatf("hold_ov_%0d", k), int'(out_valid), 1);
            chk($sformatf("hold_rdy_%0d", k), int'(in_ready), 0);
        end
        in_valid = 1'b0;
        take("hold");
        run_window(mk(1, 2, 3, 4), 0, 10, "after_hold");

        // Flush mid-window, with a sample offered on the flush cycle.
        in_valid = 1'b1; in_diff = 13'd100; step();
        in_diff = 13'(-100); step();
        flush = 1'b1; in_diff = 13'd50; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_ready", int'(in_ready), 1);
        chk("flush_ov", int'(out_valid), 0);
        chk("flush_sad", int'(out_sad), 0);
        step();
        chk("flush_sad_settled", int'(out_sad), 0);
        run_window(mk(-1, -1, -1, -1), 0, 4, "post_flush");

        // Reset asserted while draining.
        feed(mk(300, 300, 300, 300), 0, "rstdrain");
        rst_n = 1'b0;
        #2;
        chk("rstdrain_ov", int'(out_valid), 0);
        chk("rstdrain_rdy", int'(in_ready), 0);
        chk("rstdrain_sad", int'(out_sad), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rstdrain_rdy_up", int'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstdrain_no_ov_%0d", k), int'(out_valid), 0);
            step();
        end
        run_window(mk(2, 2, 2, 2), 0, 8, "post_rst");

        // Flush and out_ready together in HOLD: result dropped.
        feed(mk(9, 9, 9, 9), 0, "flushhold");
        expect_result(36, "flushhold");
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        chk("flushhold_ov", int'(out_valid), 0);
        chk("flushhold_sad", int'(out_sad), 0);
        chk("flushhold_rdy", int'(in_ready), 1);
        run_window(mk(3, 3, 3, 3), 1, 12, "post_flushhold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/diff_sad_accum.md
DIFF_SAD_ACCUM -- requirements
Module: diff_sad_accum

Interface
- REQ-001 SHALL have parameter WIN_LEN, default 16: samples per window, legal range 2..256.
- REQ-002 SHALL have parameter ACC_W, default 17: accumulator width, at least 13+clog2(WIN_LEN).
- REQ-003 SHALL have port clk, input, 1: single rising-edge clock for all state.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port in_valid, input, 1: in_diff carries a sample this cycle.
- REQ-006 SHALL have port in_diff, input, 13: signed two's-complement difference, as produced by the upstream pipelined subtractor.
- REQ-007 SHALL have port in_ready, output, 1: the block accepts a sample on an edge where in_valid and in_ready are both 1.
- REQ-008 SHALL have port flush, input, 1: synchronous abort of the current window.
- REQ-009 SHALL have port out_valid, output, 1: out_sad holds a completed window result.
- REQ-010 SHALL have port out_ready, input, 1: the consumer takes the result on an edge where out_valid and out_ready are both 1.
- REQ-011 SHALL have port out_sad, output, ACC_W: unsigned sum of |in_diff| over one window.

Function
- REQ-012 SHALL form |in_diff| as a 13-bit unsigned value; -4096 maps to 4096, with no saturation.
- REQ-013 SHALL use a two-stage pipeline: stage 1 registers the magnitude and a valid bit; stage 2 adds the registered magnitude into acc.
- REQ-014 SHALL run an FSM with four states:
  - IDLE: count=0, acc=0, in_ready=1.
  - ACCUM: in_ready=1.
  - DRAIN: in_ready=0, waiting for the pipeline to empty.
  - HOLD: in_ready=0, out_valid=1.
- REQ-015 SHALL count accepted samples; an accept in IDLE moves the FSM to ACCUM.
- REQ-016 SHALL move to DRAIN on the edge that accepts sample number WIN_LEN.
- REQ-017 SHALL move DRAIN to HOLD when the stage-1 and stage-2 valids are both clear and the last magnitude has been added.
- REQ-018 SHALL make the latency fixed: out_valid rises on the 2nd rising edge after the edge that accepts the last sample.
- REQ-019 SHALL keep out_sad and out_valid stable in HOLD until the out_valid/out_ready handshake edge.
- REQ-020 SHALL, on the handshake edge, clear acc and count, drop out_valid and go to IDLE; in_ready is 1 in the following cycle.
- REQ-021 SHALL make the total window sum fit in ACC_W bits; acc wraps modulo 2^ACC_W only if the parameter rule is violated.
- REQ-022 SHALL accept non-contiguous in_valid: bubbles do not advance count and do not disturb acc.
- REQ-023 SHALL give flush priority over every other event, in any state: clear acc, count and both pipeline valids, drop out_valid, go to IDLE on that edge.
- REQ-024 SHALL ignore an in_valid that arrives in the same cycle as flush.
- REQ-025 SHALL treat out_ready outside HOLD as don't-care, with no effect.

Reset
- REQ-026 SHALL, while rst_n=0, immediately force: FSM=IDLE, acc=0, count=0, pipeline valids=0, out_valid=0, out_sad=0, in_ready=0.
- REQ-027 SHALL raise in_ready on the first rising edge after rst_n deasserts.
- REQ-028 SHALL discard any partial window or held result when reset asserts mid-operation; no output follows.

Structure
- REQ-029 SHALL place the FSM state encoding (2-bit), the default WIN_LEN/ACC_W and the DIFF_W=13 constant in shared package sad_pkg.
- REQ-030 SHALL implement the magnitude stage (combinational abs plus stage-1 register) as sub-module abs13_stage.
- REQ-031 SHALL implement count, acc and FSM in the top module; no other sub-modules.

Verification (WIN_LEN=4, ACC_W=15)
- REQ-032 SHALL cover: in_diff 5, -3, -4096, 4095 on 4 consecutive accepts -> out_valid rises 2 edges after the 4th accept, out_sad=8199.
- REQ-033 SHALL cover: samples 1, 1, 1, 1 with in_valid bubbles between each -> out_sad=4, and count ignores the bubbles.
- REQ-034 SHALL cover: result held with out_ready=0 for 10 cycles -> out_sad=8199 stable, in_ready=0, extra in_valid ignored; out_ready=1 -> out_valid drops, in_ready=1 next cycle.
- REQ-035 SHALL cover: flush after 2 samples (100, -100), then 4 samples of -1 -> out_sad=4, with no contribution from the flushed samples.
- REQ-036 SHALL cover: rst_n pulsed low during DRAIN -> out_valid never asserts, and all outputs read 0 immediately.
- REQ-037 SHALL cover: flush and out_ready both high in HOLD -> IDLE, acc=0, and the result is dropped.
